// File: rtl/delay_load_pkg.sv
// Shared types and constants for the delay-load sequencer.
package delay_load_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SET,
    ST_SETTLE
  } state_e;

  // Largest legal fine tap; anything above is clamped to this.
  localparam logic [2:0] FINE_MAX = 3'd4;

  // Lane field is stored at a fixed width so the buffered command type does
  // not depend on the top-level parameters; LANE_W must not exceed this.
  localparam int CMD_LANE_W = 8;

  typedef struct packed {
    logic                  commit;
    logic [CMD_LANE_W-1:0] lane;
    logic [7:0]            delay;
  } cmd_t;

  // Keep the coarse tap, saturate the fine tap at FINE_MAX.
  function automatic logic [7:0] clamp_fine(input logic [7:0] d);
    return (d[2:0] > FINE_MAX) ? {d[7:3], FINE_MAX} : d;
  endfunction

endpackage

// File: rtl/delay_cmd_fifo.sv
// Small synchronous command FIFO; full/empty are decoded from the occupancy flop.
module delay_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/delay_load_seq.sv
// Delay-load sequencer: buffers per-lane writes and commits, pulses ld per lane
// on the shared delay bus, then a group-wide set followed by a settle window.
//
// state     | meaning
// ST_IDLE   | waiting for a buffered command; pops the head when present
// ST_LOAD   | one cycle: ld[lane] high, delay bus carries the new value
// ST_SET    | one cycle: set high, delay bus holds its last loaded value
// ST_SETTLE | SETTLE_CYCLES cycles of busy before the next command
module delay_load_seq
  import delay_load_pkg::*;
#(
  parameter int         NUM_LANES     = 10,
  parameter int         LANE_W        = 4,
  parameter int         FIFO_DEPTH    = 4,
  parameter logic [7:0] DEFAULT_DELAY = 8'h00,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_commit,
  input  logic [LANE_W-1:0]    cmd_lane,
  input  logic [7:0]           cmd_delay,
  output logic [NUM_LANES-1:0] ld,
  output logic                 set,
  output logic [7:0]           delay,
  output logic                 busy,
  output logic                 err_fine,
  output logic                 err_lane,
  input  logic                 err_clr,
  input  logic [LANE_W-1:0]    rd_lane,
  output logic [7:0]           rd_delay
);

  localparam int CNT_W = 8;

  cmd_t push_cmd, head_cmd;
  logic fifo_full, fifo_empty, push, pop;
  logic fine_clamp, lane_ok;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_LANES-1:0] ld_q, ld_d;
  logic                 set_q, set_d;
  logic [7:0]           delay_q, delay_d;
  logic [7:0]           shadow_q [NUM_LANES];
  logic [7:0]           shadow_d [NUM_LANES];
  logic                 err_fine_q, err_fine_d;
  logic                 err_lane_q, err_lane_d;
  logic [7:0]           rd_delay_q, rd_delay_d;

  assign cmd_ready       = !fifo_full;
  assign push            = cmd_valid && cmd_ready;
  assign fine_clamp      = (cmd_delay[2:0] > FINE_MAX);
  assign push_cmd.commit = cmd_commit;
  assign push_cmd.lane   = CMD_LANE_W'(cmd_lane);
  assign push_cmd.delay  = clamp_fine(cmd_delay);
  assign pop             = (state_q == ST_IDLE) && !fifo_empty;
  assign lane_ok         = (32'(head_cmd.lane) < NUM_LANES);

  delay_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencer next-state; strobes are computed one cycle ahead so they leave flops.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_d       = '0;
    set_d      = 1'b0;
    delay_d    = delay_q;
    shadow_d   = shadow_q;
    // A new error in the same cycle as err_clr keeps the flag set.
    err_fine_d = (err_fine_q && !err_clr) || (push && fine_clamp);
    err_lane_d = err_lane_q && !err_clr;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head_cmd.commit) begin
            state_d = ST_SET;
            set_d   = 1'b1;
          end else begin
            state_d = ST_LOAD;
            if (lane_ok) begin
              delay_d = head_cmd.delay;
              for (int i = 0; i < NUM_LANES; i++) begin
                if (32'(head_cmd.lane) == i) begin
                  ld_d[i]     = 1'b1;
                  shadow_d[i] = head_cmd.delay;
                end
              end
            end else begin
              err_lane_d = 1'b1;
            end
          end
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_SET: begin
        if (SETTLE_CYCLES == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow readback mux; out-of-range selects return the reset value.
  always_comb begin
    rd_delay_d = DEFAULT_DELAY;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (32'(rd_lane) == i) rd_delay_d = shadow_q[i];
    end
  end

  // State, output and shadow registers; reset cuts off any in-flight strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ld_q       <= '0;
      set_q      <= 1'b0;
      delay_q    <= DEFAULT_DELAY;
      err_fine_q <= 1'b0;
      err_lane_q <= 1'b0;
      rd_delay_q <= DEFAULT_DELAY;
      for (int i = 0; i < NUM_LANES; i++) shadow_q[i] <= DEFAULT_DELAY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_q       <= ld_d;
      set_q      <= set_d;
      delay_q    <= delay_d;
      err_fine_q <= err_fine_d;
      err_lane_q <= err_lane_d;
      rd_delay_q <= rd_delay_d;
      shadow_q   <= shadow_d;
    end
  end

  assign ld       = ld_q;
  assign set      = set_q;
  assign delay    = delay_q;
  assign busy     = !fifo_empty || (state_q != ST_IDLE);
  assign err_fine = err_fine_q;
  assign err_lane = err_lane_q;
  assign rd_delay = rd_delay_q;

endmodule

// File: tb/tb_delay_load_seq.sv
// Scoreboard bench for delay_load_seq: accepted commands push expected strobes,
// a monitor pops and compares whenever ld or set is seen.
module tb_delay_load_seq;

  localparam int         NUM_LANES     = 10;
  localparam int         LANE_W        = 4;
  localparam int         FIFO_DEPTH    = 4;
  localparam logic [7:0] DEFAULT_DELAY = 8'h00;
  localparam int         SETTLE_CYCLES = 2;

  logic                 clk, rst_n;
  logic                 cmd_valid, cmd_ready, cmd_commit;
  logic [LANE_W-1:0]    cmd_lane;
  logic [7:0]           cmd_delay;
  logic [NUM_LANES-1:0] ld;
  logic                 set;
  logic [7:0]           delay;
  logic                 busy, err_fine, err_lane, err_clr;
  logic [LANE_W-1:0]    rd_lane;
  logic [7:0]           rd_delay;

  delay_load_seq #(
    .NUM_LANES     (NUM_LANES),
    .LANE_W        (LANE_W),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .DEFAULT_DELAY (DEFAULT_DELAY),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_commit (cmd_commit),
    .cmd_lane   (cmd_lane),
    .cmd_delay  (cmd_delay),
    .ld         (ld),
    .set        (set),
    .delay      (delay),
    .busy       (busy),
    .err_fine   (err_fine),
    .err_lane   (err_lane),
    .err_clr    (err_clr),
    .rd_lane    (rd_lane),
    .rd_delay   (rd_delay)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         is_set;
    int         lane;
    logic [7:0] val;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;
  logic [7:0] m_shadow [NUM_LANES];
  logic [7:0] m_last;
  bit         m_err_fine, m_err_lane;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Fine tap above 4 saturates to 4, coarse tap untouched.
  function automatic logic [7:0] ref_clamp(input logic [7:0] d);
    int f;
    f = int'(d) % 8;
    if (f > 4) return 8'(int'(d) - f + 4);
    return d;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_LANES; i++) m_shadow[i] = DEFAULT_DELAY;
    m_last     = DEFAULT_DELAY;
    m_err_fine = 0;
    m_err_lane = 0;
  endfunction

  // Reference model: commands take effect in acceptance order.
  function automatic void model_accept(input bit c, input int l, input logic [7:0] d);
    exp_t       e;
    logic [7:0] v;
    if (c) begin
      e.is_set = 1; e.lane = 0; e.val = m_last;
      expq.push_back(e);
    end else begin
      v = ref_clamp(d);
      if (v != d) m_err_fine = 1;
      if (l < NUM_LANES) begin
        m_shadow[l] = v;
        m_last      = v;
        e.is_set = 0; e.lane = l; e.val = v;
        expq.push_back(e);
      end else begin
        m_err_lane = 1;
      end
    end
  endfunction

  // Monitor: every strobe cycle must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (ld != '0 || set)) begin
      pulses++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe got ld=%0h set=%0b expected none at %0t", ld, set, $time);
      end else begin
        e = expq.pop_front();
        if (e.is_set) begin
          chk("set_strobe", {21'd0, set, ld}, {21'd0, 1'b1, 10'd0});
          chk("set_delay", {24'd0, delay}, {24'd0, e.val});
        end else begin
          chk("ld_strobe", {21'd0, set, ld}, {21'd0, 1'b0, NUM_LANES'(1) << e.lane});
          chk("ld_delay", {24'd0, delay}, {24'd0, e.val});
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input bit c, input int l, input logic [7:0] d);
    int n = 0;
    cmd_valid  = 1'b1;
    cmd_commit = c;
    cmd_lane   = LANE_W'(l);
    cmd_delay  = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(c, l, d);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("drain_queue", expq.size(), 0);
  endtask

  task automatic check_shadows();
    for (int i = 0; i < NUM_LANES; i++) begin
      rd_lane = LANE_W'(i);
      @(negedge clk);
      chk($sformatf("shadow_%0d", i), {24'd0, rd_delay}, {24'd0, m_shadow[i]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    cmd_valid = 0; cmd_commit = 0; cmd_lane = '0; cmd_delay = '0;
    err_clr = 0; rd_lane = '0;
    rst_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // reset state
    chk("rst_ld", 32'(ld), 0);
    chk("rst_set", 32'(set), 0);
    chk("rst_delay", 32'(delay), 32'(DEFAULT_DELAY));
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_err", {30'd0, err_fine, err_lane}, 0);
    chk("rst_rd", 32'(rd_delay), 32'(DEFAULT_DELAY));

    // commit with empty history: single set, delay stays at default
    send(1, 0, 8'h00);
    wait_idle();
    chk("empty_commit_delay", 32'(delay), 32'(DEFAULT_DELAY));

    // write lane 3 then commit, with latency and settle timing
    send(0, 3, 8'h2C);
    chk("lat_busy", 32'(busy), 1);
    chk("lat_ld_early", 32'(ld), 0);
    @(negedge clk);
    chk("lat_ld3", 32'(ld), 32'h008);
    send(1, 0, 8'h00);
    @(negedge clk);
    chk("commit_set", 32'(set), 1);
    @(negedge clk);
    chk("settle_busy1", 32'(busy), 1);
    @(negedge clk);
    chk("settle_busy2", 32'(busy), 1);
    @(negedge clk);
    chk("settle_done", 32'(busy), 0);
    rd_lane = 4'd3;
    @(negedge clk);
    chk("rd_lane3", 32'(rd_delay), 32'h2C);

    // fine clamp and sticky clear
    send(0, 0, 8'h0F);
    chk("err_fine_set", 32'(err_fine), 1);
    wait_idle();
    rd_lane = 4'd0;
    @(negedge clk);
    chk("rd_lane0_clamped", 32'(rd_delay), 32'h0C);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    m_err_fine = 0; m_err_lane = 0;
    chk("err_fine_clr", 32'(err_fine), 0);

    // back-to-back writes behind a commit fill the buffer
    send(1, 0, 8'h00);
    send(0, 1, 8'h11);
    send(0, 2, 8'h22);
    send(0, 4, 8'h43);
    send(0, 5, 8'h54);
    chk("full_ready_low", 32'(cmd_ready), 0);
    send(0, 6, 8'h60);
    send(0, 7, 8'h7B);
    wait_idle();

    // out-of-range lane
    chk("err_lane_pre", 32'(err_lane), 0);
    send(0, 12, 8'h55);
    wait_idle();
    chk("err_lane_set", 32'(err_lane), 1);
    check_shadows();

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      bit c;
      int l;
      c = ($urandom_range(0, 3) == 0);
      l = $urandom_range(0, NUM_LANES + 1);
      send(c, l, 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    chk("rand_err_fine", 32'(err_fine), 32'(m_err_fine));
    chk("rand_err_lane", 32'(err_lane), 32'(m_err_lane));
    check_shadows();

    // reset during SETTLE with two writes still queued
    send(1, 0, 8'h00);
    send(0, 8, 8'h11);
    send(0, 9, 8'h22);
    rst_n = 0;
    expq.delete();
    model_reset();
    #1;
    chk("mid_rst_ld", 32'(ld), 0);
    chk("mid_rst_set", 32'(set), 0);
    chk("mid_rst_delay", 32'(delay), 32'(DEFAULT_DELAY));
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    p0 = pulses;
    repeat (10) @(negedge clk);
    chk("post_rst_no_strobe", pulses - p0, 0);
    chk("post_rst_busy", 32'(busy), 0);
    check_shadows();

    chk("final_queue", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_load_seq.md
# delay_load_seq

Delay-load sequencer that drives the `ld`/`set`/`delay[7:0]` control side of a group of fine-pipelined input-delay lanes. It accepts per-lane delay write and commit commands from the register/calibration logic and buffers them. It pulses each lane's `ld` with the shared delay bus, then issues one group-wide `set` so all lanes switch together. It keeps a shadow copy of every lane's loaded value for readback.

## Interface
- `NUM_LANES`, 10, number of delay lanes driven (1..32)
- `LANE_W`, 4, width of lane index; must be at least ceil(log2(NUM_LANES))
- `FIFO_DEPTH`, 4, command buffer entries (power of 2)
- `DEFAULT_DELAY`, 0, 8-bit delay the lanes hold after reset; shadow reset value
- `SETTLE_CYCLES`, 2, busy cycles after `set` before the next load
- `clk`  in  1  single clock; all ports synchronous to it
- `rst_n`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command buffer not full
- `cmd_commit`  in  1  1 = commit (issue `set`); 0 = write delay to lane
- `cmd_lane`  in  LANE_W  target lane for a write; ignored for commit
- `cmd_delay`  in  8  [7:3] coarse tap, [2:0] fine tap
- `ld`  out  NUM_LANES  one-hot per-lane load strobe
- `set`  out  1  group apply strobe
- `delay`  out  8  shared delay bus to all lanes
- `busy`  out  1  buffer non-empty or sequencer not in IDLE
- `err_fine`  out  1  sticky: a fine value >4 was clamped
- `err_lane`  out  1  sticky: a write addressed lane >= NUM_LANES
- `err_clr`  in  1  clears both sticky flags
- `rd_lane`  in  LANE_W  shadow readback select
- `rd_delay`  out  8  registered shadow value of `rd_lane`

## Operation
- Handshake: a command is accepted when `cmd_valid && cmd_ready` at a rising edge. `cmd_ready` = buffer not full. When full, the command is not taken and the producer holds it.
- Clamping on accept: if `cmd_delay[2:0] > 4`, the stored value is `{cmd_delay[7:3],3'd4}` and `err_fine` is set. The fine range is 0..4.
- States:
  - IDLE: on buffer non-empty, pop the head. A write goes to LOAD; a commit goes to SET.
  - LOAD: for 1 cycle, drive `ld[lane]=1` and `delay=value`, and update shadow[lane]. Then return to IDLE.
  - SET: for 1 cycle, drive `set=1`. Then go to SETTLE.
  - SETTLE: count SETTLE_CYCLES, then return to IDLE.
- Out-of-range lane: the entry is popped and LOAD runs with all `ld` at 0. The shadow is unchanged and `err_lane` is set.
- `delay` holds its last loaded value outside LOAD. It never glitches while `set` is high.
- Writes with no commit are loaded into the lane pipelines but stay inactive until the next `set`. Repeated writes to a lane before a commit: the last write wins.
- Commit with no pending writes still pulses `set`. This is harmless re-apply.
- `err_clr` in the same cycle as a new error: the error wins and the flag stays set.

## Timing
- Reset values (async assert, sync-clean deassert):
  - `ld` = 0, `set` = 0, `delay` = DEFAULT_DELAY, `busy` = 0, `cmd_ready` = 1
  - `err_*` = 0, buffer empty
  - all shadows = DEFAULT_DELAY, `rd_delay` = DEFAULT_DELAY
- Latency, buffer empty and IDLE: command accepted at edge N gives `ld`/`set` high for cycle N+1 to N+2.
- Throughput:
  - write: 2 cycles per entry (IDLE + LOAD)
  - commit: 2 + SETTLE_CYCLES cycles
- `busy` goes high the cycle after accept. It falls the cycle after the sequencer re-enters IDLE with the buffer empty.
- Push and pop in the same cycle when full: the pop frees the slot, but `cmd_ready` is registered from occupancy, so the push waits one cycle.
- `rd_delay` has 1-cycle latency from `rd_lane`. Reading a lane during its LOAD returns the new value the following cycle.
- Reset mid-sequence: pending commands are dropped, and any in-flight `ld`/`set` is cut off immediately.

## Structure
- Package `delay_load_pkg`:
  - state enum {IDLE, LOAD, SET, SETTLE}
  - `FINE_MAX = 3'd4`
  - command struct {commit, lane, delay}
- Sub-module `delay_cmd_fifo`: synchronous FIFO with parameterised depth and width, full/empty flags, asynchronous active-low reset.
- Top level: FSM, clamp logic, shadow register array, sticky flags.

## Test plan
- Reset, then write lane 3 = 0x2C, then commit. Expect `ld[3]` for 1 cycle with `delay=0x2C`, then `set` 1 cycle, then `busy` high for SETTLE_CYCLES, then `rd_delay(3)=0x2C`.
- Write lane 0 = 0x0F. Expect stored value 0x0C, `err_fine=1`. Then `err_clr` gives `err_fine=0`.
- Issue 6 back-to-back writes with FIFO_DEPTH=4. Expect `cmd_ready` low after 4 entries, and all 6 `ld` pulses in order with correct lanes and values.
- Write lane 12 with NUM_LANES=10. Expect no `ld` bit, `err_lane=1`, and all shadows unchanged.
- Deassert `rst_n` during the SETTLE of a commit with 2 writes queued. Expect all outputs at reset values immediately and no further `ld`/`set` after release.
- Commit with an empty history. Expect a single `set` pulse, and `delay` stays DEFAULT_DELAY.
